// File: rtl/ysyx_22040750_if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding fetch at a time,
// and holds the fetched {pc, inst} on the IF->ID valid/allowin handshake.
// Redirects override the PC and discard any fetch still in flight or held.
module ysyx_22040750_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    output logic        O_imem_req_valid,
    output logic [31:0] O_imem_addr,
    input  logic        I_imem_req_ready,
    input  logic        I_imem_resp_valid,
    input  logic [31:0] I_imem_rdata,
    input  logic        I_redirect_valid,
    input  logic [31:0] I_redirect_pc,
    input  logic        I_IF_ID_allowin,
    output logic        O_IF_ID_valid,
    output logic [31:0] O_pc,
    output logic [31:0] O_inst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        drop;          // in-flight response belongs to a squashed fetch
    logic        req_fire;
    logic        out_fire;
    logic        capture;
    logic [31:0] redirect_tgt;

    assign req_fire     = O_imem_req_valid & I_imem_req_ready;
    assign out_fire     = O_IF_ID_valid & I_IF_ID_allowin;
    // Redirect targets are word aligned; low two bits are simply cleared.
    assign redirect_tgt = I_redirect_pc & ~32'h3;
    // A response is kept only if nothing squashed it before or during arrival.
    assign capture      = (state == WAIT) & I_imem_resp_valid & ~drop & ~I_redirect_valid;

    // State register
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; any redirect ends up back in REQ at the new PC
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (req_fire) state_nxt = WAIT;
            WAIT: if (I_imem_resp_valid) state_nxt = (drop | I_redirect_valid) ? REQ : HOLD;
            HOLD: if (out_fire | I_redirect_valid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; the address is always the live PC
    always_comb begin
        O_imem_req_valid = (state == REQ);
        O_IF_ID_valid    = (state == HOLD);
        O_imem_addr      = pc;
    end

    // Drop flag: set when a redirect lands on an accepted-but-unanswered fetch
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            drop <= 1'b0;
        end else begin
            case (state)
                REQ:     if (req_fire) drop <= I_redirect_valid;
                WAIT: begin
                    if (I_imem_resp_valid)     drop <= 1'b0;
                    else if (I_redirect_valid) drop <= 1'b1;
                end
                default: drop <= 1'b0;
            endcase
        end
    end

    // PC: redirect wins over sequential advance on a completed transfer
    always_ff @(posedge I_sys_clk) begin
        if (I_rst)                             pc <= RESET_PC;
        else if (I_redirect_valid)             pc <= redirect_tgt;
        else if ((state == HOLD) && out_fire)  pc <= pc + PC_STEP;
    end

    // Output holding register, loaded only from a kept response
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            O_pc   <= 32'd0;
            O_inst <= 32'd0;
        end else if (capture) begin
            O_pc   <= pc;
            O_inst <= I_imem_rdata;
        end
    end

endmodule

// File: doc/ysyx_22040750_if_fetch.md
Name: ysyx_22040750_if_fetch

Overview:
Instruction-fetch stage that drives the IF->ID valid/allowin handshake as the transmitter side. It owns the PC, issues single-outstanding requests to instruction memory, and captures each response into an output holding register. It presents {pc, inst} downstream until accepted, and handles redirects (jump/branch/trap) by discarding in-flight or held fetches.

Parameters:
RESET_PC, 32'h80000000, PC fetched first after reset release
PC_STEP, 4, sequential PC increment in bytes

Ports:
I_sys_clk  in  1  clock
I_rst  in  1  reset
O_imem_req_valid  out  1  fetch request valid
O_imem_addr  out  32  fetch address (current PC)
I_imem_req_ready  in  1  memory accepts request this cycle
I_imem_resp_valid  in  1  fetch data valid (one-cycle pulse)
I_imem_rdata  in  32  fetched instruction
I_redirect_valid  in  1  redirect pulse from EX/WB
I_redirect_pc  in  32  redirect target
I_IF_ID_allowin  in  1  downstream can accept
O_IF_ID_valid  out  1  {O_pc,O_inst} valid for downstream
O_pc  out  32  PC of presented instruction
O_inst  out  32  presented instruction

Behaviour:
- Reset is I_rst, synchronous, active-high; clock is I_sys_clk.
- Reset values: state=IDLE, pc=RESET_PC, drop=0, O_imem_req_valid=0, O_IF_ID_valid=0, O_pc=0, O_inst=0. O_imem_addr always equals pc.
- req_fire = O_imem_req_valid & I_imem_req_ready. out_fire = O_IF_ID_valid & I_IF_ID_allowin.
- States:
  - IDLE: go to REQ unconditionally (first request one cycle after reset release).
  - REQ: O_imem_req_valid=1. On req_fire, go to WAIT. Otherwise stay; address held stable.
  - WAIT: no request. On I_imem_resp_valid with drop=0: O_pc<=pc, O_inst<=I_imem_rdata, O_IF_ID_valid<=1, go to HOLD. With drop=1: discard the data, clear drop, go to REQ.
  - HOLD: O_IF_ID_valid=1; O_pc/O_inst held stable. On out_fire: pc<=pc+PC_STEP, O_IF_ID_valid<=0, go to REQ.
- Latency: with ready=1 and response one cycle after accept, an instruction is presented 2 cycles after entering REQ. Steady-state throughput is 1 instruction per 3 cycles.
- At most one outstanding memory request. I_imem_resp_valid outside WAIT is ignored.
- PC arithmetic is modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- Redirect (highest priority): pc<=I_redirect_pc with bits [1:0] forced to 0.
  - IDLE/REQ without req_fire: stay or enter REQ at the new PC. The new address appears the next cycle.
  - REQ with req_fire in the same cycle: go to WAIT with drop=1; the old response is discarded, then REQ at the target.
  - WAIT: drop<=1. A response in the same cycle is discarded immediately: go to REQ with drop=0.
  - WAIT with drop already 1: target updated, drop stays 1.
  - HOLD: O_IF_ID_valid<=0 and go to REQ. If out_fire is in the same cycle, the transfer still completes (downstream squashes it). pc takes the redirect target, not pc+4.
- Reset mid-operation aborts everything; the memory is reset by the same I_rst, so there are no stale responses.
- O_IF_ID_valid never deasserts without out_fire, except on redirect or reset.

Test Plan:
- Reset 2 cycles, ready=1, resp 1 cycle after accept, allowin=1 -> req addr 0x80000000, then O_IF_ID_valid with O_pc=0x80000000 and O_inst=rdata. Next req addr is 0x80000004; 4 sequential PCs in order.
- Hold allowin=0 for 5 cycles in HOLD -> O_pc/O_inst/O_IF_ID_valid stable, no O_imem_req_valid. Release -> exactly one transfer, next addr pc+4.
- ready=0 for 3 cycles in REQ -> O_imem_addr stable and req_valid held high. No WAIT entry until ready=1.
- Redirect to 0x80001000 in WAIT, resp 2 cycles later with 0xDEADBEEF -> no O_IF_ID_valid, next req addr 0x80001000. Repeat with redirect and resp in the same cycle.
- Redirect to 0x80000102 in the same cycle as req_fire -> first response dropped, next req addr 0x80000100.
- Redirect in HOLD with allowin=1 -> one transfer of the old pc, then next req addr equals the target. Start pc=0xFFFFFFFC -> next addr 0x00000000.
